shift_sched: RTL and testbench

SHIFT_SCHED -- requirements
Module: shift_sched

---
 rtl/shift_pkg.sv | 13 +
 rtl/rr_arb2.sv | 35 +++
 rtl/shift_sched.sv | 123 ++++++++++++
 tb/tb_shift_sched.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared FSM state type and sizing constants for shift_sched
package shift_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int NUM_REQ   = 2;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin pointer and grant selection
module rr_arb2
    import shift_pkg::*;
(
    input  logic               clk,
    input  logic               res,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);

    logic ptr_q;
    logic ptr_d;

    // ptr_q holds the index of the requester favoured on a tie
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr_q ? 2'b10 : 2'b01;
        end
        ptr_d = ptr_q;
        if (en && (req != 2'b00)) begin
            ptr_d = grant[0];
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/shift_sched.sv
// rtl/shift_sched.sv - arbitrated parallel-to-serial shifter; SHIFT_SCHED_PARITY_EN appends an even-parity bit
module shift_sched
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               res,
    input  logic [NUM_REQ-1:0] req,
    input  logic [WIDTH-1:0]   data0,
    input  logic [WIDTH-1:0]   data1,
    output logic [NUM_REQ-1:0] gnt,
    output logic               sdo,
    output logic               sen,
    output logic               busy,
    output logic               done,
    output logic               owner
);

`ifdef SHIFT_SCHED_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int             CW   = $clog2(NBITS + 1);
    localparam logic [CW-1:0]  LAST = CW'(NBITS - 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     buf_q, buf_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 owner_q, owner_d;
    logic [NUM_REQ-1:0]   arb_grant;
`ifdef SHIFT_SCHED_PARITY_EN
    logic                 par_q, par_d;
`endif

    rr_arb2 u_arb (
        .clk   (clk),
        .res   (res),
        .en    (state_q == S_IDLE),
        .req   (req),
        .grant (arb_grant)
    );

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        owner_d = owner_q;
        sdo     = 1'b0;
        sen     = 1'b0;
        done    = 1'b0;
        busy    = 1'b1;
`ifdef SHIFT_SCHED_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (req != '0) begin
                    state_d = S_SHIFT;
                    buf_d   = arb_grant[1] ? data1 : data0;
                    cnt_d   = '0;
                    gnt_d   = arb_grant;
                    owner_d = arb_grant[1];
`ifdef SHIFT_SCHED_PARITY_EN
                    par_d   = ^buf_d;
`endif
                end
            end
            S_SHIFT: begin
                sen = 1'b1;
                sdo = buf_q[WIDTH-1];
`ifdef SHIFT_SCHED_PARITY_EN
                // the data bits have all left the buffer; the last slot carries parity
                if (cnt_q == CW'(WIDTH)) begin
                    sdo = par_q;
                end
`endif
                buf_d = buf_q << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            owner_q <= 1'b0;
`ifdef SHIFT_SCHED_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
`ifdef SHIFT_SCHED_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;

endmodule

// File: tb/tb_shift_sched.sv
// tb/tb_shift_sched.sv - self-checking bench for shift_sched (honours SHIFT_SCHED_PARITY_EN)
module tb_shift_sched;

    localparam int W = 4;
`ifdef SHIFT_SCHED_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk = 1'b0;
    logic         res = 1'b0;
    logic [1:0]   req = 2'b00;
    logic [W-1:0] data0 = '0;
    logic [W-1:0] data1 = '0;
    logic [1:0]   gnt;
    logic         sdo, sen, busy, done, owner;

    int n_tests = 0;
    int n_fail  = 0;

    shift_sched #(.WIDTH(W)) dut (
        .clk   (clk),
        .res   (res),
        .req   (req),
        .data0 (data0),
        .data1 (data1),
        .gnt   (gnt),
        .sdo   (sdo),
        .sen   (sen),
        .busy  (busy),
        .done  (done),
        .owner (owner)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // serial frame for one word, MSB first, parity appended when enabled
    function automatic logic [NB-1:0] frame(input logic [W-1:0] d);
`ifdef SHIFT_SCHED_PARITY_EN
        return {d, ^d};
`else
        return d;
`endif
    endfunction

    task automatic do_reset();
        res = 1'b1;
        req = 2'b00;
        tick();
        res = 1'b0;
    endtask

    task automatic test_reset();
        res = 1'b1;
        req = 2'b11;
        data0 = 4'hF;
        data1 = 4'hF;
        tick();
        n_tests++;
        if ({gnt, sdo, sen, busy, done, owner} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gnt=%b sdo=%b sen=%b busy=%b done=%b owner=%b, want all 0",
                     gnt, sdo, sen, busy, done, owner);
        end
        res = 1'b0;
        req = 2'b00;
    endtask

    task automatic test_single();
        logic [NB-1:0] f;
        do_reset();
        data0 = 4'b1011;
        f = frame(4'b1011);
        req = 2'b01;
        tick();
        req = 2'b00;
        n_tests++;
        if (gnt !== 2'b01 || owner !== 1'b0) begin
            n_fail++;
            $display("FAIL single_grant: got gnt=%b owner=%b, want 01/0", gnt, owner);
        end
        for (int i = 0; i < NB; i++) begin
            n_tests++;
            if (sen !== 1'b1 || sdo !== f[NB-1-i] || busy !== 1'b1 || done !== 1'b0 || (i > 0 && gnt !== 2'b00)) begin
                n_fail++;
                $display("FAIL single_bit%0d: got sen=%b sdo=%b busy=%b done=%b gnt=%b, want 1/%b/1/0",
                         i, sen, sdo, busy, done, gnt, f[NB-1-i]);
            end
            tick();
        end
        n_tests++;
        if (done !== 1'b1 || sen !== 1'b0 || sdo !== 1'b0 || owner !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: got done=%b sen=%b sdo=%b owner=%b, want 1/0/0/0", done, sen, sdo, owner);
        end
        tick();
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: got busy=%b done=%b, want 0/0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        logic [NB-1:0] f0, f1;
        do_reset();
        data0 = 4'b1100;
        data1 = 4'b0011;
        f0 = frame(4'b1100);
        f1 = frame(4'b0011);
        req = 2'b11;
        tick();
        req = 2'b10;
        n_tests++;
        if (gnt !== 2'b01 || owner !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first_grant: got gnt=%b owner=%b, want 01/0", gnt, owner);
        end
        for (int i = 0; i < NB; i++) begin
            n_tests++;
            if (sen !== 1'b1 || sdo !== f0[NB-1-i]) begin
                n_fail++;
                $display("FAIL b2b_first_bit%0d: got sen=%b sdo=%b, want 1/%b", i, sen, sdo, f0[NB-1-i]);
            end
            tick();
        end
        n_tests++;
        if (done !== 1'b1 || gnt !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_done: got done=%b gnt=%b, want 1/00", done, gnt);
        end
        tick();
        n_tests++;
        if (busy !== 1'b0 || gnt !== 2'b00 || sen !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap_idle: got busy=%b gnt=%b sen=%b, want 0/00/0", busy, gnt, sen);
        end
        tick();
        req = 2'b00;
        n_tests++;
        if (gnt !== 2'b10 || owner !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second_grant: got gnt=%b owner=%b, want 10/1", gnt, owner);
        end
        for (int i = 0; i < NB; i++) begin
            n_tests++;
            if (sen !== 1'b1 || sdo !== f1[NB-1-i]) begin
                n_fail++;
                $display("FAIL b2b_second_bit%0d: got sen=%b sdo=%b, want 1/%b", i, sen, sdo, f1[NB-1-i]);
            end
            tick();
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second_done: got done=%b, want 1", done);
        end
        tick();
    endtask

    task automatic test_ignore_midshift();
        int extra_gnt;
        do_reset();
        data1 = 4'b0110;
        req = 2'b10;
        tick();
        req = 2'b00;
        tick();
        req = 2'b01;
        tick();
        req = 2'b00;
        extra_gnt = 0;
        for (int i = 0; i < NB + 4; i++) begin
            if (gnt !== 2'b00) extra_gnt++;
            tick();
        end
        n_tests++;
        if (extra_gnt != 0 || busy !== 1'b0 || owner !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_midshift: got extra_gnt=%0d busy=%b owner=%b, want 0/0/1", extra_gnt, busy, owner);
        end
    endtask

    task automatic test_reset_midshift();
        logic [NB-1:0] f;
        int saw_done;
        do_reset();
        data0 = 4'b1011;
        req = 2'b01;
        tick();
        req = 2'b00;
        tick();
        res = 1'b1;
        tick();
        res = 1'b0;
        n_tests++;
        if (sen !== 1'b0 || sdo !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || gnt !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid: got sen=%b sdo=%b busy=%b done=%b gnt=%b, want all 0", sen, sdo, busy, done, gnt);
        end
        saw_done = 0;
        for (int i = 0; i < NB + 2; i++) begin
            if (done === 1'b1 || busy === 1'b1) saw_done++;
            tick();
        end
        n_tests++;
        if (saw_done != 0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: got %0d busy/done cycles, want 0", saw_done);
        end
        data1 = 4'b0101;
        f = frame(4'b0101);
        req = 2'b10;
        tick();
        req = 2'b00;
        n_tests++;
        if (gnt !== 2'b10 || owner !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_regrant: got gnt=%b owner=%b, want 10/1", gnt, owner);
        end
        for (int i = 0; i < NB; i++) begin
            n_tests++;
            if (sen !== 1'b1 || sdo !== f[NB-1-i]) begin
                n_fail++;
                $display("FAIL reset_mid_bit%0d: got sen=%b sdo=%b, want 1/%b", i, sen, sdo, f[NB-1-i]);
            end
            tick();
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_done: got done=%b, want 1", done);
        end
        tick();
    endtask

    // model: each accepted request schedules NB shift slots, one done slot, one idle slot
    task automatic test_random();
        logic [5:0] sched[$];
        logic [5:0] exp;
        logic [NB-1:0] f;
        int fav, who, exp_owner;
        do_reset();
        fav = 0;
        exp_owner = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if ($urandom_range(0, 3) != 0) req = 2'($urandom_range(0, 3));
            data0 = 4'($urandom);
            data1 = 4'($urandom);
            if (sched.size() == 0 && req != 2'b00) begin
                if (req == 2'b11) who = fav;
                else who = req[1] ? 1 : 0;
                fav = 1 - who;
                exp_owner = who;
                f = frame(who == 1 ? data1 : data0);
                for (int i = 0; i < NB; i++) begin
                    sched.push_back({(i == 0) ? (2'b01 << who) : 2'b00, 1'b1, f[NB-1-i], 1'b1, 1'b0});
                end
                sched.push_back(6'b00_0_0_1_1);
                sched.push_back(6'b00_0_0_0_0);
            end
            exp = (sched.size() != 0) ? sched.pop_front() : 6'b0;
            tick();
            n_tests++;
            if ({gnt, sen, sdo, busy, done} !== exp || owner !== exp_owner[0]) begin
                n_fail++;
                $display("FAIL random_cyc%0d: got gnt/sen/sdo/busy/done=%b owner=%b, want %b owner=%0d",
                         cyc, {gnt, sen, sdo, busy, done}, owner, exp, exp_owner);
            end
        end
        req = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore_midshift();
        test_reset_midshift();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
